// File: rtl/alu_pkg.sv
// Shared constants for the ALU execute stage: one-hot op encodings, FSM states
// and flag bit positions.
package alu_pkg;

  localparam int OP_W = 12;

  localparam int OPB_AND     = 0;
  localparam int OPB_OR      = 1;
  localparam int OPB_NOT     = 2;
  localparam int OPB_XOR     = 3;
  localparam int OPB_NAND    = 4;
  localparam int OPB_NOR     = 5;
  localparam int OPB_XNOR    = 6;
  localparam int OPB_ADD     = 7;
  localparam int OPB_SUB     = 8;
  localparam int OPB_SHRIGHT = 9;
  localparam int OPB_SHLEFT  = 10;
  localparam int OPB_CLEAR   = 11;

  localparam logic [OP_W-1:0] OP_AND     = OP_W'(1) << OPB_AND;
  localparam logic [OP_W-1:0] OP_OR      = OP_W'(1) << OPB_OR;
  localparam logic [OP_W-1:0] OP_NOT     = OP_W'(1) << OPB_NOT;
  localparam logic [OP_W-1:0] OP_XOR     = OP_W'(1) << OPB_XOR;
  localparam logic [OP_W-1:0] OP_NAND    = OP_W'(1) << OPB_NAND;
  localparam logic [OP_W-1:0] OP_NOR     = OP_W'(1) << OPB_NOR;
  localparam logic [OP_W-1:0] OP_XNOR    = OP_W'(1) << OPB_XNOR;
  localparam logic [OP_W-1:0] OP_ADD     = OP_W'(1) << OPB_ADD;
  localparam logic [OP_W-1:0] OP_SUB     = OP_W'(1) << OPB_SUB;
  localparam logic [OP_W-1:0] OP_SHRIGHT = OP_W'(1) << OPB_SHRIGHT;
  localparam logic [OP_W-1:0] OP_SHLEFT  = OP_W'(1) << OPB_SHLEFT;
  localparam logic [OP_W-1:0] OP_CLEAR   = OP_W'(1) << OPB_CLEAR;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic v, input logic c);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Iterative one-bit-per-cycle logical shifter: work register plus down-counter.
// The shifted-out bit is only exposed when ALU_FLAGS_EN is defined.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               dir_left,
  input  logic [SHAMT_W-1:0] amt,
  input  logic [WIDTH-1:0]   din,
  output logic               done,
  output logic [WIDTH-1:0]   next_val
`ifdef ALU_FLAGS_EN
  ,
  output logic               last_out
`endif
);

  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] cnt;
  logic               left;

  // done marks the cycle whose step produces the final value, so the caller
  // can capture next_val on the same edge the counter hits zero.
  assign done     = (cnt == SHAMT_W'(1));
  assign next_val = left ? {work[WIDTH-2:0], 1'b0} : {1'b0, work[WIDTH-1:1]};
`ifdef ALU_FLAGS_EN
  assign last_out = left ? work[WIDTH-1] : work[0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work <= '0;
      cnt  <= '0;
      left <= 1'b0;
    end else if (start) begin
      work <= din;
      cnt  <= amt;
      left <= dir_left;
    end else if (cnt != '0) begin
      work <= next_val;
      cnt  <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with valid/ready on both sides and iterative shifts.
// Define ALU_FLAGS_EN to compute and register {N,Z,V,C}; otherwise flags is tied to zero.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err
);

  state_t             state_q, state_d;
  logic               accept, op_legal, is_shift, start_shift, sh_done;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res, sh_next;
`ifdef ALU_FLAGS_EN
  logic               sh_last;
`endif

  assign in_ready    = (state_q == IDLE) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign op_legal    = (op != '0) && ((op & (op - OP_W'(1))) == '0);
  assign shamt       = b[SHAMT_W-1:0];
  assign is_shift    = (op == OP_SHRIGHT) || (op == OP_SHLEFT);
  assign start_shift = accept && is_shift && (shamt != '0);

  // Single-cycle datapath; zero-amount shifts pass a through, illegal ops give 0.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_AND:              alu_res = a & b;
      OP_OR:               alu_res = a | b;
      OP_NOT:              alu_res = ~a;
      OP_XOR:              alu_res = a ^ b;
      OP_NAND:             alu_res = ~(a & b);
      OP_NOR:              alu_res = ~(a | b);
      OP_XNOR:             alu_res = ~(a ^ b);
      OP_ADD:              alu_res = a + b;
      OP_SUB:              alu_res = a - b;
      OP_SHRIGHT, OP_SHLEFT: alu_res = a;
      default:             alu_res = '0;
    endcase
  end

  alu_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_shift),
    .dir_left (op == OP_SHLEFT),
    .amt      (shamt),
    .din      (a),
    .done     (sh_done),
    .next_val (sh_next)
`ifdef ALU_FLAGS_EN
    ,
    .last_out (sh_last)
`endif
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_shift) state_d = SHIFT;
      SHIFT:   if (sh_done)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accepting a multi-cycle shift implies the slot was drained on that edge,
  // so out_valid drops until the shifter finishes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      err       <= 1'b0;
    end else if (state_q == SHIFT && sh_done) begin
      out_valid <= 1'b1;
      result    <= sh_next;
      err       <= 1'b0;
    end else if (accept && !start_shift) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      err       <= !op_legal;
    end else if (accept || out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] add_full;
  logic           alu_c, alu_v;
  logic [3:0]     alu_flags, sh_flags, flags_q;

  assign add_full = {1'b0, a} + {1'b0, b};

  always_comb begin
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      OP_ADD: begin
        alu_c = add_full[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_c = (a < b);
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      default: ;
    endcase
    alu_flags = op_legal ? pack_flags(alu_res[WIDTH-1], alu_res == '0, alu_v, alu_c)
                         : 4'b0000;
    sh_flags  = pack_flags(sh_next[WIDTH-1], sh_next == '0, 1'b0, sh_last);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                            flags_q <= 4'b0000;
    else if (state_q == SHIFT && sh_done)  flags_q <= sh_flags;
    else if (accept && !start_shift)       flags_q <= alu_flags;
  end

  assign flags = flags_q;
`else
  assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed cases with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_alu_exec_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] op = '0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, err;
  logic [15:0] result;
  logic [3:0]  flags;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  alu_exec_stage #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .err       (err)
  );

  function automatic logic [3:0] expFlags(input logic [3:0] f);
`ifdef ALU_FLAGS_EN
    return f;
`else
    return (f & 4'b0000);
`endif
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from plain arithmetic: result, {N,Z,V,C}, err, shift cycles.
  task automatic refOp(input logic [11:0] o, input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] r, output logic [3:0] f, output logic e,
                       output int n);
    int sx, sy, s, amt;
    logic [31:0] wide;
    logic c, v;
    r = '0; c = 1'b0; v = 1'b0; e = 1'b0; n = 0; f = '0;
    sx = int'($signed(x));
    sy = int'($signed(y));
    amt = int'(y[3:0]);
    if ($countones(o) != 1) begin
      e = 1'b1;
    end else begin
      case (o)
        OP_AND:  r = x & y;
        OP_OR:   r = x | y;
        OP_NOT:  r = ~x;
        OP_XOR:  r = x ^ y;
        OP_NAND: r = ~(x & y);
        OP_NOR:  r = ~(x | y);
        OP_XNOR: r = ~(x ^ y);
        OP_ADD: begin
          wide = 32'(x) + 32'(y);
          r = wide[15:0];
          c = wide > 32'd65535;
          s = sx + sy;
          v = (s > 32767) || (s < -32768);
        end
        OP_SUB: begin
          r = x - y;
          c = x < y;
          s = sx - sy;
          v = (s > 32767) || (s < -32768);
        end
        OP_SHLEFT: begin
          wide = 32'(x) << amt;
          r = wide[15:0];
          c = (amt != 0) && wide[16];
          n = amt;
        end
        OP_SHRIGHT: begin
          r = x >> amt;
          c = (amt != 0) && (((32'(x) >> (amt - 1)) & 32'd1) != 0);
          n = amt;
        end
        default: r = '0;
      endcase
      f = {r[15], r == 16'h0000, v, c};
    end
  endtask

  logic        m_ov = 1'b0, m_err = 1'b0;
  logic [15:0] m_res = '0, p_res = '0;
  logic [3:0]  m_flags = '0, p_flags = '0;
  int          m_busy = 0;

  // Model advances on every clock edge using the inputs the DUT also sees.
  always @(posedge clk) begin
    logic rdy, e;
    logic [15:0] r;
    logic [3:0]  f;
    int n;
    if (!rst_n) begin
      m_ov = 1'b0; m_res = '0; m_flags = '0; m_err = 1'b0; m_busy = 0;
    end else begin
      rdy = (m_busy == 0) && (!m_ov || out_ready);
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_ov = 1'b1; m_res = p_res; m_flags = p_flags; m_err = 1'b0;
        end
      end else if (in_valid && rdy) begin
        refOp(op, a, b, r, f, e, n);
        if (n > 0) begin
          m_busy = n; p_res = r; p_flags = expFlags(f); m_ov = 1'b0;
        end else begin
          m_ov = 1'b1; m_res = r; m_flags = expFlags(f); m_err = e;
        end
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      cmp("model_in_ready", in_ready, (m_busy == 0) && (!m_ov || out_ready));
      cmp("model_out_valid", out_valid, m_ov);
      if (m_ov) begin
        cmp("model_result", result, m_res);
        cmp("model_flags", flags, m_flags);
        cmp("model_err", err, m_err);
      end
    end
  end

  task automatic applyStimulus(input logic [11:0] o, input logic [15:0] x, input logic [15:0] y);
    int budget;
    bit acc;
    budget = 50;
    acc = 1'b0;
    op = o; a = x; b = y; in_valid = 1'b1;
    while (!acc && budget > 0) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget--;
    end
    in_valid = 1'b0;
    cmp("accept_timeout", acc, 1'b1);
  endtask

  task automatic waitOutput(output int lows);
    int budget;
    budget = 40;
    lows = 0;
    @(negedge clk);
    while (!out_valid && budget > 0) begin
      if (!in_ready) lows++;
      budget--;
      @(negedge clk);
    end
    cmp("output_timeout", out_valid, 1'b1);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] r, input logic [3:0] f,
                             input logic e);
    cmp({name, "_valid"}, out_valid, 1'b1);
    cmp({name, "_result"}, result, r);
    cmp({name, "_flags"}, flags, expFlags(f));
    cmp({name, "_err"}, err, e);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] pickOp();
    int k;
    k = $urandom_range(0, 14);
    if (k < 12)       return 12'(1) << k;
    else if (k == 12) return 12'($urandom);
    else if (k == 13) return 12'b000000000011;
    else              return '0;
  endfunction

  function automatic logic [15:0] pickData();
    case ($urandom_range(0, 5))
      0:       return 16'hFFFF;
      1:       return 16'h8000;
      2:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int lows;
    $display("[TB] start");
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("reset_out_valid", out_valid, 1'b0);
    cmp("reset_result", result, 16'h0000);
    cmp("reset_flags", flags, 4'b0000);
    cmp("reset_err", err, 1'b0);
    cmp("reset_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checking = 1'b1;
    drain();

    applyStimulus(OP_ADD, 16'hFFFF, 16'h0001);
    waitOutput(lows);
    checkOutput("add_wrap", 16'h0000, 4'b0101, 1'b0);
    drain();

    applyStimulus(OP_SUB, 16'h8000, 16'h0001);
    waitOutput(lows);
    checkOutput("sub_ovf", 16'h7FFF, 4'b0010, 1'b0);
    drain();

    applyStimulus(OP_SHLEFT, 16'h8001, 16'h0003);
    waitOutput(lows);
    cmp("shl3_busy_cycles", lows, 3);
    checkOutput("shl3", 16'h0008, 4'b0000, 1'b0);
    drain();

    applyStimulus(OP_SHLEFT, 16'h8001, 16'h0001);
    waitOutput(lows);
    cmp("shl1_busy_cycles", lows, 1);
    checkOutput("shl1", 16'h0002, 4'b0001, 1'b0);
    drain();

    out_ready = 1'b0;
    applyStimulus(OP_AND, 16'hF0F0, 16'h0FF0);
    repeat (4) begin
      @(negedge clk);
      checkOutput("hold_and", 16'h00F0, 4'b0000, 1'b0);
      cmp("hold_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(OP_OR, 16'h1234, 16'h4321);
    @(negedge clk);
    checkOutput("no_gap_or", 16'h5335, 4'b0000, 1'b0);
    drain();

    applyStimulus(12'b000000000011, 16'h1234, 16'h5678);
    waitOutput(lows);
    checkOutput("illegal_two", 16'h0000, 4'b0000, 1'b1);
    drain();

    applyStimulus(12'b000000000000, 16'hFFFF, 16'hFFFF);
    waitOutput(lows);
    checkOutput("illegal_zero", 16'h0000, 4'b0000, 1'b1);
    drain();

    applyStimulus(OP_SHRIGHT, 16'hABCD, 16'h000F);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    cmp("midshift_reset_out_valid", out_valid, 1'b0);
    cmp("midshift_reset_in_ready", in_ready, 1'b1);
    repeat (20) begin
      @(negedge clk);
      cmp("midshift_no_stale", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    repeat (3000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = pickOp();
      a         = pickData();
      b         = pickData();
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    drain();
    repeat (40) @(posedge clk);
    #1;
    checking = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
